// File: rtl/gals_pkg.sv
// Shared types and defaults for the inter-core GALS event link.
package gals_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } en2req_st_e;

  localparam int SYNC_STG_DEF = 2;

endpackage

// File: rtl/sync_chain.sv
// Reset-able flop chain for bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STG-1:0] r_ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ff <= '0;
    end else begin
      r_ff[0] <= i_d;
      for (int i = 1; i < STG; i++) r_ff[i] <= r_ff[i-1];
    end
  end

  assign o_q = r_ff[STG-1];

endmodule

// File: rtl/en2req_tx.sv
// Enable-pulse to four-phase req/ack transmitter with pending-event replay.
// Optional handshake abort compiled in with EN2REQ_TIMEOUT_EN.
module en2req_tx
  import gals_pkg::*;
#(
  parameter int SYNC_STG = SYNC_STG_DEF,
  parameter int DW_PEND  = 4,
  parameter int TO_CYC   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               ack,
  output logic               req,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic [DW_PEND-1:0] pend,
  output logic               timeout
);

  localparam logic [DW_PEND-1:0] PEND_ONE = DW_PEND'(1);

  en2req_st_e         r_st, w_st_nxt;
  logic               w_ack_s;
  logic               w_hs_end;
  logic               w_to_hit;
  logic               w_ovf_nxt;
  logic [DW_PEND-1:0] w_pend_nxt;

  sync_chain #(.STG(SYNC_STG)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .i_d (ack),
    .o_q (w_ack_s)
  );

`ifdef EN2REQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Age of the current handshake phase; restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst || r_st == IDLE || w_st_nxt != r_st) r_to_cnt <= '0;
    else                                         r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_to_hit = (r_st != IDLE) && (r_to_cnt == TO_W'(TO_CYC - 1));
`else
  assign w_to_hit = 1'b0;
`endif

  // State register; all outputs registered from next-cycle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= IDLE;
      req     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      pend    <= '0;
      timeout <= 1'b0;
    end else begin
      r_st    <= w_st_nxt;
      req     <= (w_st_nxt == REQ_HI);
      busy    <= (w_st_nxt != IDLE);
      done    <= w_hs_end;
      ovf     <= w_ovf_nxt;
      pend    <= w_pend_nxt;
      timeout <= w_to_hit;
    end
  end

  // Next state
  always_comb begin
    w_st_nxt = r_st;
    w_hs_end = 1'b0;
    unique case (r_st)
      IDLE:   if (en) w_st_nxt = REQ_HI;
      REQ_HI: if (w_ack_s) w_st_nxt = REQ_LO;
      REQ_LO: if (!w_ack_s) begin
        w_hs_end = 1'b1;
        w_st_nxt = (pend != '0 || en) ? REQ_HI : IDLE;
      end
      default: w_st_nxt = IDLE;
    endcase
    if (w_to_hit) begin
      w_st_nxt = IDLE;
      w_hs_end = 1'b0;
    end
  end

  // Pending counter and overflow
  always_comb begin
    w_pend_nxt = pend;
    w_ovf_nxt  = 1'b0;
    if (w_hs_end) begin
      // A replayed event frees one slot; a same-cycle en refills it.
      if (pend != '0 && !en) w_pend_nxt = pend - PEND_ONE;
    end else if (en && r_st != IDLE) begin
      if (&pend) w_ovf_nxt  = 1'b1;
      else       w_pend_nxt = pend + PEND_ONE;
    end
    if (w_to_hit) begin
      w_pend_nxt = '0;
      w_ovf_nxt  = 1'b0;
    end
  end

endmodule
